// File: rtl/siaa_seq_pkg.sv
// Shared types and constants for the SIAA program sequencer.
// Optional feature macro used by the sequencer: PROG_SEQ_CYCLES_EN (RUN-cycle counter).
package siaa_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seq_state_t;

    localparam logic BR_ABS = 1'b0;
    localparam logic BR_REL = 1'b1;

    localparam int unsigned PC_LUT_INIT_LEN = 16;

    // Entries are sign-extended to 32 bits so truncation to any D <= 32 keeps
    // negative relative offsets (e.g. -4 becomes 0xFFC for D = 12).
    localparam logic [31:0] PC_LUT_INIT [PC_LUT_INIT_LEN] = '{
        32'h0000_0000, 32'h0000_0010, 32'hFFFF_FFFC, 32'h0000_0040,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
    };

endpackage

// File: rtl/pc_lut.sv
// Combinational branch-target lookup table, contents taken from PC_LUT_INIT.
// Entries beyond the package table read as zero.
module pc_lut
    import siaa_seq_pkg::*;
#(
    parameter int unsigned D      = 12,
    parameter int unsigned LUT_AW = 4
) (
    input  logic [LUT_AW-1:0] br_idx,
    output logic [D-1:0]      target
);

    localparam int LutDepth = 2 ** LUT_AW;
    localparam int InitLen  = PC_LUT_INIT_LEN;

    logic [D-1:0] lut [LutDepth];

    // Build the ROM image at elaboration time
    for (genvar g = 0; g < LutDepth; g++) begin : g_lut
        if (g < InitLen) begin : g_init
            assign lut[g] = D'($signed(PC_LUT_INIT[g]));
        end else begin : g_zero
            assign lut[g] = '0;
        end
    end

    assign target = lut[br_idx];

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: program counter, IDLE/RUN/DONE control and LUT branches.
// Optional macro PROG_SEQ_CYCLES_EN adds the saturating RUN-cycle counter output.
module prog_sequencer
    import siaa_seq_pkg::*;
#(
    parameter int unsigned D        = 12,
    parameter int unsigned LUT_AW   = 4,
    parameter int unsigned END_ADDR = 128,
    parameter int unsigned CW       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              br_en,
    input  logic              br_cond,
    input  logic              br_mode,
    input  logic [LUT_AW-1:0] br_idx,
    input  logic              halt,
    output logic [D-1:0]      prog_ctr,
    output logic              fetch_en,
    output logic              busy,
`ifdef PROG_SEQ_CYCLES_EN
    output logic              done,
    output logic [CW-1:0]     cycles
`else
    output logic              done
`endif
);

    localparam logic [D-1:0] EndPc = D'(END_ADDR);

    seq_state_t   state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [D-1:0] br_target;
    logic [D-1:0] next_pc;

    pc_lut #(
        .D      (D),
        .LUT_AW (LUT_AW)
    ) u_pc_lut (
        .br_idx (br_idx),
        .target (br_target)
    );

    // State and PC registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Candidate next PC for a committing non-halt instruction (wraps modulo 2^D)
    always_comb begin
        next_pc = pc_q + D'(1);
        if (br_en && br_cond) begin
            next_pc = (br_mode == BR_REL) ? pc_q + br_target : br_target;
        end
    end

    // Next-state and next-PC selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    pc_d    = '0;
                end
            end
            StRun: begin
                if (fetch_en) begin
                    if (halt) begin
                        state_d = StDone;
                    end else begin
                        pc_d = next_pc;
                        if (next_pc == EndPc) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                pc_d    = '0;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        fetch_en = (state_q == StRun) && !stall;
        busy     = (state_q == StRun);
        done     = (state_q == StDone);
    end

    assign prog_ctr = pc_q;

`ifdef PROG_SEQ_CYCLES_EN
    logic [CW-1:0] cycles_q, cycles_d;

    // Cycle counter: cleared on entry to RUN, saturating count while in RUN
    always_comb begin
        cycles_d = cycles_q;
        if (state_q != StRun) begin
            if (start) begin
                cycles_d = '0;
            end
        end else if (cycles_q != {CW{1'b1}}) begin
            cycles_d = cycles_q + CW'(1);
        end
    end

    // Cycle counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer with a queue-based scoreboard.
// A second instance with END_ADDR = 64 shares all inputs to check branch-to-end.
module tb_prog_sequencer;

    localparam int unsigned D      = 12;
    localparam int unsigned LUT_AW = 4;
    localparam int unsigned CW     = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stall;
    logic              br_en;
    logic              br_cond;
    logic              br_mode;
    logic [LUT_AW-1:0] br_idx;
    logic              halt;
    logic [D-1:0]      prog_ctr, prog_ctr64;
    logic              fetch_en, fetch_en64;
    logic              busy, busy64;
    logic              done, done64;
`ifdef PROG_SEQ_CYCLES_EN
    logic [CW-1:0]     cycles, cycles64;
`endif

    always #5 clk = ~clk;

    prog_sequencer #(
        .D        (D),
        .LUT_AW   (LUT_AW),
        .END_ADDR (128),
        .CW       (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stall    (stall),
        .br_en    (br_en),
        .br_cond  (br_cond),
        .br_mode  (br_mode),
        .br_idx   (br_idx),
        .halt     (halt),
        .prog_ctr (prog_ctr),
        .fetch_en (fetch_en),
        .busy     (busy),
`ifdef PROG_SEQ_CYCLES_EN
        .done     (done),
        .cycles   (cycles)
`else
        .done     (done)
`endif
    );

    prog_sequencer #(
        .D        (D),
        .LUT_AW   (LUT_AW),
        .END_ADDR (64),
        .CW       (CW)
    ) dut64 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stall    (stall),
        .br_en    (br_en),
        .br_cond  (br_cond),
        .br_mode  (br_mode),
        .br_idx   (br_idx),
        .halt     (halt),
        .prog_ctr (prog_ctr64),
        .fetch_en (fetch_en64),
        .busy     (busy64),
`ifdef PROG_SEQ_CYCLES_EN
        .done     (done64),
        .cycles   (cycles64)
`else
        .done     (done64)
`endif
    );

    typedef struct {
        logic [D-1:0]  pc;
        logic          busy;
        logic          done;
        logic          chk_cyc;
        logic [CW-1:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, check fetch_en before the edge, then score the registered outputs
    task automatic step(input int st, input int sl, input int be, input int bc, input int bm,
                        input int bi, input int hl, input int exp_fe, input int epc,
                        input int eb, input int ed, input int cc, input int ecyc);
        exp_t e;
        start   = 1'(st);
        stall   = 1'(sl);
        br_en   = 1'(be);
        br_cond = 1'(bc);
        br_mode = 1'(bm);
        br_idx  = LUT_AW'(bi);
        halt    = 1'(hl);
        #1;
        check("fetch_en", 32'(fetch_en), 32'(exp_fe));
        e.pc      = D'(epc);
        e.busy    = 1'(eb);
        e.done    = 1'(ed);
        e.chk_cyc = 1'(cc);
        e.cyc     = CW'(ecyc);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("prog_ctr", 32'(prog_ctr), 32'(e.pc));
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
`ifdef PROG_SEQ_CYCLES_EN
        if (e.chk_cyc) check("cycles", 32'(cycles), 32'(e.cyc));
`endif
    endtask

    // Plain sequential commit
    task automatic nop(input int epc);
        step(0, 0, 0, 0, 0, 0, 0, 1, epc, 1, 0, 0, 0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stall   = 1'b0;
        br_en   = 1'b0;
        br_cond = 1'b0;
        br_mode = 1'b0;
        br_idx  = '0;
        halt    = 1'b0;

        // Reset values, before any clock edge
        #3;
        check("rst_prog_ctr", 32'(prog_ctr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_fetch_en", 32'(fetch_en), 32'h0);
`ifdef PROG_SEQ_CYCLES_EN
        check("rst_cycles", 32'(cycles), 32'h0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Start, then 128 unstalled commits reach END_ADDR
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 128; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, i + 1, (i != 127) ? 1 : 0, (i == 127) ? 1 : 0, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 128, 0, 1, 0, 0);

        // Restart from DONE, absolute branch taken at PC 5
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        for (int i = 1; i <= 5; i++) nop(i);
        step(0, 0, 1, 1, 0, 1, 0, 1, 'h010, 1, 0, 0, 0);

        // Start while running is ignored
        step(1, 0, 0, 0, 0, 0, 0, 1, 'h011, 1, 0, 0, 0);

        // Back to 0, then a not-taken branch at PC 5
        step(0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) nop(i);
        step(0, 0, 1, 0, 0, 1, 0, 1, 6, 1, 0, 0, 0);

        // Relative -4 from PC 2 wraps to 0xFFE, then sequential wrap through 0
        step(0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        nop(1);
        nop(2);
        step(0, 0, 1, 1, 1, 2, 0, 1, 'hFFE, 1, 0, 0, 0);
        nop('hFFF);
        nop(0);

        // Halt at PC 9, DONE holds, both instances in lockstep
        for (int i = 1; i <= 9; i++) nop(i);
        step(0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0);
        check("dut64_halt_pc", 32'(prog_ctr64), 32'h9);
        check("dut64_halt_done", 32'(done64), 32'h1);

        // Restart clears cycles; stall three cycles at PC 7 with a branch pending
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        for (int i = 1; i <= 7; i++) step(0, 0, 0, 0, 0, 0, 0, 1, i, 1, 0, 1, i);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 1, 0, 0, 7, 1, 0, 1, 8 + i);
        step(0, 0, 1, 1, 0, 1, 0, 1, 'h010, 1, 0, 1, 11);

        // Absolute branch to 0x040: stays in RUN at END_ADDR 128, finishes at END_ADDR 64
        step(0, 0, 1, 1, 0, 3, 0, 1, 'h040, 1, 0, 1, 12);
        check("dut64_end_pc", 32'(prog_ctr64), 32'h40);
        check("dut64_end_done", 32'(done64), 32'h1);
        check("dut64_end_busy", 32'(busy64), 32'h0);
        nop('h041);

        // Asynchronous reset mid-cycle during RUN
        #2;
        reset = 1'b1;
        #1;
        check("arst_prog_ctr", 32'(prog_ctr), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_fetch_en", 32'(fetch_en), 32'h0);
        check("arst_dut64_done", 32'(done64), 32'h0);
`ifdef PROG_SEQ_CYCLES_EN
        check("arst_cycles", 32'(cycles), 32'h0);
`endif
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
